// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 UART receiver with valid/ack holding register; define UART_RX_PARITY_EN for an even-parity bit
module uart_rx #(
  parameter int CLK_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  input  logic       rdata_ack,
  output logic       ferr,
  output logic       overrun,
  output logic       perr
);
  localparam int HALF_BIT = CLK_PER_BIT / 2;
  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP, BREAK
  } state_t;
  state_t r_state, w_nstate;
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic [2:0] r_bitidx, w_nidx;
  logic [7:0] r_shift, w_nshift, r_rdata;
  logic r_valid, r_ferr, r_overrun, r_perr;
  logic w_rxs, w_stop, w_perr, w_good;
`ifdef UART_RX_PARITY_EN
  logic r_par, w_npar;
  assign w_perr = w_stop & (^r_shift ^ r_par);
`else
  assign w_perr = 1'b0;
`endif
  assign w_rxs = r_sync[1];
  assign w_good = w_stop & w_rxs & ~w_perr;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_nstate;
  always_comb begin
    w_nstate = r_state;
    w_ncnt = r_cnt + 1'b1;
    w_nidx = r_bitidx;
    w_nshift = r_shift;
    w_stop = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_npar = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_ncnt = '0;
        w_nstate = w_rxs ? IDLE : START;
      end
      START: if (r_cnt == HALF_LAST) begin
        w_ncnt = '0;
        w_nidx = '0;
        w_nstate = w_rxs ? IDLE : DATA;
      end
      DATA: if (r_cnt == LAST) begin
        w_ncnt = '0;
        w_nshift = {w_rxs, r_shift[7:1]};
        w_nidx = r_bitidx + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (r_bitidx == 3'd7) w_nstate = PARITY;
`else
        if (r_bitidx == 3'd7) w_nstate = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (r_cnt == LAST) begin
        w_ncnt = '0;
        w_npar = w_rxs;
        w_nstate = STOP;
      end
`endif
      // leave on the stop-bit midpoint so a start edge in its second half is caught
      STOP: if (r_cnt == LAST) begin
        w_ncnt = '0;
        w_stop = 1'b1;
        w_nstate = w_rxs ? IDLE : BREAK;
      end
      BREAK: begin
        w_ncnt = '0;
        w_nstate = w_rxs ? IDLE : BREAK;
      end
      default: begin
        w_ncnt = '0;
        w_nstate = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
      r_bitidx <= '0;
      r_shift <= '0;
      r_rdata <= '0;
      r_valid <= 1'b0;
      r_ferr <= 1'b0;
      r_overrun <= 1'b0;
      r_perr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], rxd};
      r_cnt <= w_ncnt;
      r_bitidx <= w_nidx;
      r_shift <= w_nshift;
      r_ferr <= w_stop & ~w_rxs;
      r_perr <= w_perr;
      r_overrun <= w_good & r_valid & ~rdata_ack;
      r_valid <= w_good | (r_valid & ~rdata_ack);
      if (w_good) r_rdata <= r_shift;
`ifdef UART_RX_PARITY_EN
      r_par <= w_npar;
`endif
    end
  end
  assign rdata = r_rdata;
  assign rdata_valid = r_valid;
  assign ferr = r_ferr;
  assign overrun = r_overrun;
  assign perr = r_perr;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the core's serial transmit path.
- Oversamples the asynchronous `rxd` line, recovers 8N1 frames LSB-first, and presents each byte in a one-entry holding register with a valid/ack handshake to the core.
- Reports framing errors and overruns as one-cycle pulses.
- Sits beside the transmitter at the processor level; `rxd` is driven from a top-level pin.

Parameters:
- CLK_PER_BIT, 868, clk cycles per bit period (100 MHz / 115200); must be ≥ 4.
- HALF_BIT, CLK_PER_BIT/2, cycles from the start-bit edge to the start-bit midpoint (derived; not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial line; idle high.
- rdata  output  8  last received byte.
- rdata_valid  output  1  high while rdata holds an unconsumed byte.
- rdata_ack  input  1  consumer takes rdata this cycle; ignored when rdata_valid=0.
- ferr  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: new byte overwrote an unconsumed byte.
- perr  output  1  one-cycle pulse: parity mismatch (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. While rst=1 at a clk edge:
  - state=IDLE, counters=0;
  - the two-flop synchronizer loads 1;
  - rdata=8'h00; rdata_valid, ferr, overrun and perr all 0.
  - A reset mid-frame discards the partial frame; no error pulse is produced.
- Synchronizer: rxd passes through 2 flops; rxs is the second flop's output. All decisions use rxs only.
- Counters:
  - cnt counts bit-period cycles; it resets to 0 on every state change and on every bit sample.
  - bitidx (3 bits) counts data bits 0–7.
- IDLE: when rxs=0, go to START with cnt=0.
- START: increment cnt. When cnt = HALF_BIT-1, sample rxs:
  - rxs=0 → DATA, cnt=0, bitidx=0;
  - rxs=1 → IDLE. This is a glitch reject; no error is raised.
- DATA: increment cnt. When cnt = CLK_PER_BIT-1:
  - shift register ← {rxs, shift[7:1]} (first received bit ends in bit 0);
  - cnt=0 and bitidx+1;
  - after bit 7, go to STOP (or PARITY when the feature is enabled).
- STOP: when cnt = CLK_PER_BIT-1, sample rxs (this is the stop-bit midpoint):
  - rxs=1 → frame good. Next cycle: rdata=shift, rdata_valid=1. Go to IDLE immediately so a start edge arriving within the second half of the stop bit is caught.
  - rxs=0 → ferr=1 for 1 cycle; rdata and rdata_valid unchanged; go to BREAK.
- BREAK: wait until rxs=1, then go to IDLE. A held-low line produces exactly one ferr, not repeated frames.
- Handshake and buffer:
  - rdata_ack=1 with rdata_valid=1 clears rdata_valid next cycle.
  - Good frame completing in the same cycle as ack: rdata loads the new byte, rdata_valid stays 1, no overrun.
  - Good frame completing while rdata_valid=1 and no ack: rdata is overwritten, overrun=1 for 1 cycle.
- Latency: rdata_valid rises 1 cycle after the stop-sample edge. That edge is HALF_BIT + 9×CLK_PER_BIT cycles (±1) after rxs first falls, plus 2 cycles of synchronizer delay from the rxd edge.
- Pulses ferr, overrun and perr never last more than 1 cycle and are mutually independent.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - a PARITY state is inserted between DATA and STOP; it samples the 9th bit at its midpoint;
  - even parity: XOR of the 8 data bits and the parity bit must be 0;
  - on mismatch, perr pulses 1 cycle when the stop bit is sampled; the byte is dropped (rdata and rdata_valid unchanged) and STOP handling otherwise proceeds as normal.
- Undefined: 8N1 only; perr tied to 0; no PARITY state.

Test Plan (CLK_PER_BIT=16):
- Reset, then send 8'hA5 as an 8N1 frame → rdata=8'hA5, rdata_valid=1 about 154 cycles after the start edge; ack → valid=0 next cycle.
- 4-cycle low glitch on idle rxd → no state exit beyond START, rdata_valid stays 0, no pulses.
- Send 8'h3C with stop bit forced 0, then line high → ferr pulse exactly once, rdata_valid=0; a following 8'h55 frame is received correctly.
- Send 8'h11 then 8'h22 back-to-back without ack → rdata=8'h22, overrun pulse once; with ack asserted in the completion cycle of 8'h22 → no overrun, valid stays 1.
- Assert rst mid-frame (after bit 3 of 8'hFF), then send 8'h0F → only 8'h0F delivered, no error pulses.
- With UART_RX_PARITY_EN: 8'h07 with parity=1 → delivered; with parity=0 → perr pulse, byte dropped, rdata_valid=0.
